// File: rtl/sync_fifo_flagged_if.sv
// Handshake and status bundle between a sync_fifo_flagged and its producer/consumer.
// The master side drives requests; the slave side (the FIFO) drives data and status.
interface sync_fifo_flagged_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    logic                     w_en;
    logic                     r_en;
    logic [WIDTH-1:0]         data_in;
    logic                     clr_err;
    logic [WIDTH-1:0]         data_out;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output w_en, r_en, data_in, clr_err,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  w_en, r_en, data_in, clr_err,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through output.
module sync_fifo_flagged #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_fifo_flagged_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flagged: DEPTH must be a power of 2 and >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("sync_fifo_flagged: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $error("sync_fifo_flagged: AE_THRESH must be in 0..DEPTH-1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sync_fifo_flagged: WIDTH must be >= 1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;

    logic             is_empty;
    logic             is_full;
    logic             rd_acc;
    logic             wr_acc;

    // Acceptance is decided purely from pre-edge state; a read never bypasses into an empty FIFO.
    always_comb begin
        is_empty = (count_q == '0);
        is_full  = (count_q == CW'(DEPTH));
        rd_acc   = bus.r_en && !is_empty;
        wr_acc   = bus.w_en && (!is_full || rd_acc);
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end

        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        // Clear first so a same-cycle rejection still leaves the flag set.
        if (bus.clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (bus.w_en && !wr_acc) begin
            overflow_d = 1'b1;
        end
        if (bus.r_en && !rd_acc) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            data_out_q  <= data_out_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    always_comb begin
        bus.count        = count_q;
        bus.full         = is_full;
        bus.empty        = is_empty;
        bus.almost_full  = (count_q >= CW'(AF_THRESH));
        bus.almost_empty = (count_q <= CW'(AE_THRESH));
        bus.overflow     = overflow_q;
        bus.underflow    = underflow_q;
        if (FWFT != 0) begin
            bus.data_out = is_empty ? '0 : mem_q[rd_ptr_q];
        end else begin
            bus.data_out = data_out_q;
        end
    end
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Randomised scoreboard bench for sync_fifo_flagged: one registered-read and one FWFT
// instance share the same stimulus and are checked against a queue-based model.
module tb_sync_fifo_flagged;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    typedef struct {
        int         cnt;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       ov;
        logic       uf;
        logic [7:0] d0;
        logic [7:0] d1;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] data_in = '0;

    int checks = 0;
    int failures = 0;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    logic       m_ov = 1'b0;
    logic       m_uf = 1'b0;
    logic [7:0] m_d0 = '0;

    sync_fifo_flagged_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if0 ();
    sync_fifo_flagged_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if1 ();

    assign if0.w_en = w_en;
    assign if0.r_en = r_en;
    assign if0.clr_err = clr_err;
    assign if0.data_in = data_in;
    assign if1.w_en = w_en;
    assign if1.r_en = r_en;
    assign if1.clr_err = clr_err;
    assign if1.data_in = data_in;

    sync_fifo_flagged #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0))
        u_reg (.clk(clk), .rst_n(rst_n), .bus(if0));
    sync_fifo_flagged #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1))
        u_fwft (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_flags(input exp_t e);
        chk("reg.count", int'(if0.count), e.cnt);
        chk("reg.full", int'(if0.full), int'(e.full));
        chk("reg.empty", int'(if0.empty), int'(e.empty));
        chk("reg.almost_full", int'(if0.almost_full), int'(e.af));
        chk("reg.almost_empty", int'(if0.almost_empty), int'(e.ae));
        chk("reg.overflow", int'(if0.overflow), int'(e.ov));
        chk("reg.underflow", int'(if0.underflow), int'(e.uf));
        chk("reg.data_out", int'(if0.data_out), int'(e.d0));
        chk("fwft.count", int'(if1.count), e.cnt);
        chk("fwft.empty", int'(if1.empty), int'(e.empty));
        chk("fwft.full", int'(if1.full), int'(e.full));
        chk("fwft.overflow", int'(if1.overflow), int'(e.ov));
        chk("fwft.underflow", int'(if1.underflow), int'(e.uf));
        chk("fwft.data_out", int'(if1.data_out), int'(e.d1));
    endtask

    function automatic exp_t model_state();
        exp_t e;
        e.cnt   = mq.size();
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.af    = (mq.size() >= AF);
        e.ae    = (mq.size() <= AE);
        e.ov    = m_ov;
        e.uf    = m_uf;
        e.d0    = m_d0;
        e.d1    = (mq.size() > 0) ? mq[0] : 8'h00;
        return e;
    endfunction

    // One clock edge: apply the FIFO rules to the model and queue the post-edge expectation.
    task automatic step();
        bit rd;
        bit wr;
        @(posedge clk);
        rd = r_en && (mq.size() > 0);
        wr = w_en && ((mq.size() < DEPTH) || rd);
        m_ov = (w_en && !wr) || (m_ov && !clr_err);
        m_uf = (r_en && !rd) || (m_uf && !clr_err);
        if (rd) m_d0 = mq.pop_front();
        if (wr) mq.push_back(data_in);
        exp_q.push_back(model_state());
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] d, input logic c);
        w_en = w;
        r_en = r;
        data_in = d;
        clr_err = c;
        step();
    endtask

    task automatic model_reset();
        mq.delete();
        m_ov = 1'b0;
        m_uf = 1'b0;
        m_d0 = '0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_flags(e);
            end
        end
    end

    initial begin : driver
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk_flags(model_state());
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 1; i <= 8; i++) drive(1'b1, 1'b0, 8'(i), 1'b0);
        drive(1'b1, 1'b0, 8'hFF, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'($urandom_range(0, 255)), 1'b0);
        drive(1'b1, 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 8'h00, 1'b0);

        drive(1'b1, 1'b0, 8'h5A, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
        w_en = 1'b0;
        r_en = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk_flags(model_state());
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b0, 8'h3C, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        for (int ph = 0; ph < 4; ph++) begin
            int wp;
            wp = (ph == 0) ? 80 : (ph == 2) ? 20 : 50;
            for (int i = 0; i < 120; i++) begin
                drive(logic'($urandom_range(0, 99) < wp),
                      logic'($urandom_range(0, 99) < (100 - wp)),
                      8'($urandom_range(0, 255)),
                      logic'($urandom_range(0, 9) == 0));
            end
        end
        w_en = 1'b0;
        r_en = 1'b0;
        clr_err = 1'b0;

        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
